// File: rtl/axi4_lite_write_master_ctrl_pkg.sv
// Shared types and defaults for the AXI4-Lite write master.
// Response codes, protection encodings and controller states.
package Axi4LiteWriteMasterGlobalPkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 32;
    localparam int DATA_WIDTH_DEFAULT    = 32;
    localparam int DELAY_WIDTH_DEFAULT   = 5;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } brespEnum;

    typedef enum logic [2:0] {
        PROT_DATA_SEC_UNPRIV   = 3'b000,
        PROT_DATA_SEC_PRIV     = 3'b001,
        PROT_DATA_NSEC_UNPRIV  = 3'b010,
        PROT_DATA_NSEC_PRIV    = 3'b011,
        PROT_INSTR_SEC_UNPRIV  = 3'b100,
        PROT_INSTR_SEC_PRIV    = 3'b101,
        PROT_INSTR_NSEC_UNPRIV = 3'b110,
        PROT_INSTR_NSEC_PRIV   = 3'b111
    } awprotEnum;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2,
        DONE      = 2'd3
    } stateEnum;

endpackage

// File: rtl/axi4_lite_write_master_ctrl_delay_counter.sv
// Loadable saturating down-counter; zero_o flags that the count
// will be zero after the coming edge, so callers can register outputs.
module axi4_lite_delay_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_d == '0);

endmodule

// File: rtl/axi4_lite_write_master_ctrl.sv
// AXI4-Lite write initiator: one outstanding write, independent AW/W,
// programmable WVALID and BREADY delays, timeout flag.
module axi4_lite_write_master_ctrl
    import Axi4LiteWriteMasterGlobalPkg::*;
#(
    parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int DELAY_WIDTH    = DELAY_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [2:0]                req_prot,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [DELAY_WIDTH-1:0]    req_wvalid_delay,
    input  logic [DELAY_WIDTH-1:0]    req_bready_delay,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [ADDRESS_WIDTH-1:0]  awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    stateEnum                   state_q;
    logic                       req_ready_q;
    logic                       awvalid_q;
    logic                       wvalid_q;
    logic                       w_done_q;
    logic                       bready_q;
    logic                       rsp_valid_q;
    logic                       rsp_timeout_q;
    brespEnum                   rsp_resp_q;
    logic [ADDRESS_WIDTH-1:0]   awaddr_q;
    logic [2:0]                 awprot_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH/8-1:0]    wstrb_q;
    logic [DELAY_WIDTH-1:0]     bdelay_q;
    logic [TW-1:0]              tmo_q;
    logic [TW-1:0]              tmo_d;

    logic                       accept;
    logic                       aw_hs;
    logic                       w_hs;
    logic                       b_hs;
    logic                       both_done;
    logic                       busy_now;
    logic                       busy_next;
    logic                       tmo_pulse;
    logic                       cnt_load;
    logic [DELAY_WIDTH-1:0]     cnt_val;
    logic                       cnt_dec;
    logic                       cnt_zero;

    always_comb begin
        accept    = (state_q == IDLE) && req_valid;
        aw_hs     = awvalid_q && awready;
        w_hs      = wvalid_q && wready;
        b_hs      = bready_q && bvalid;
        busy_now  = (state_q == ADDR_DATA) || (state_q == RESP);
        both_done = (state_q == ADDR_DATA) && (!awvalid_q || aw_hs)
                    && (w_done_q || w_hs);
        busy_next = accept || (busy_now && !(state_q == RESP && b_hs));
        cnt_load  = accept || both_done;
        cnt_val   = accept ? req_wvalid_delay : bdelay_q;
        cnt_dec   = busy_now;
        tmo_d     = '0;
        if (accept) begin
            tmo_d = TW'(1);
        end else if (busy_now) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        end
        tmo_pulse = TMO_EN && busy_next && (tmo_d == TMO_MAX)
                    && (tmo_q != TMO_MAX);
    end

    // One counter serves both delays: WVALID in ADDR_DATA, BREADY in RESP.
    axi4_lite_delay_counter #(
        .WIDTH (DELAY_WIDTH)
    ) u_delay (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            w_done_q      <= 1'b0;
            bready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_resp_q    <= OKAY;
            awaddr_q      <= '0;
            awprot_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bdelay_q      <= '0;
            tmo_q         <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= tmo_pulse;
            tmo_q         <= tmo_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        awaddr_q    <= req_addr;
                        awprot_q    <= req_prot;
                        wdata_q     <= req_data;
                        wstrb_q     <= req_strb;
                        bdelay_q    <= req_bready_delay;
                        awvalid_q   <= 1'b1;
                        wvalid_q    <= (req_wvalid_delay == '0);
                        w_done_q    <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end else if (!wvalid_q && !w_done_q && cnt_zero) begin
                        wvalid_q <= 1'b1;
                    end
                    if (both_done) begin
                        bready_q <= (bdelay_q == '0);
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= brespEnum'(bresp);
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (!bready_q && cnt_zero) begin
                        bready_q <= 1'b1;
                    end
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign awaddr      = awaddr_q;
    assign awprot      = awprot_q;
    assign awvalid     = awvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master_ctrl.sv
// Bench for axi4_lite_write_master_ctrl: timestamp-based reference
// model checked every cycle, plus directed literal checks.
module tb_axi4_lite_write_master_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int DLW = 5;
    localparam int TO  = 16;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [AW-1:0]  req_addr = '0;
    logic [2:0]     req_prot = '0;
    logic [DW-1:0]  req_data = '0;
    logic [SW-1:0]  req_strb = '0;
    logic [DLW-1:0] req_wvalid_delay = '0;
    logic [DLW-1:0] req_bready_delay = '0;
    logic           rsp_valid;
    logic [1:0]     rsp_resp;
    logic           rsp_timeout;
    logic [AW-1:0]  awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready = 1'b0;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  wstrb;
    logic           wvalid;
    logic           wready = 1'b0;
    logic [1:0]     bresp = '0;
    logic           bvalid = 1'b0;
    logic           bready;

    always #5 aclk = ~aclk;

    axi4_lite_write_master_ctrl #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .DELAY_WIDTH    (DLW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_prot         (req_prot),
        .req_data         (req_data),
        .req_strb         (req_strb),
        .req_wvalid_delay (req_wvalid_delay),
        .req_bready_delay (req_bready_delay),
        .rsp_valid        (rsp_valid),
        .rsp_resp         (rsp_resp),
        .rsp_timeout      (rsp_timeout),
        .awaddr           (awaddr),
        .awprot           (awprot),
        .awvalid          (awvalid),
        .awready          (awready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .wvalid           (wvalid),
        .wready           (wready),
        .bresp            (bresp),
        .bvalid           (bvalid),
        .bready           (bready)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic ck1(input string nm, input logic act, input logic exp);
        chk(nm, 64'(act), 64'(exp));
    endtask

    // Model: a transaction is described by the cycles of its events.
    bit             m_busy = 1'b0;
    int             t_acc, t_aw, t_w, t_rs, t_b;
    int             m_wd, m_bd;
    logic [AW-1:0]  m_addr = '0;
    logic [2:0]     m_prot = '0;
    logic [DW-1:0]  m_data = '0;
    logic [SW-1:0]  m_strb = '0;
    logic [1:0]     m_resp = '0;

    function automatic void model_reset();
        m_busy = 1'b0;
        m_addr = '0;
        m_prot = '0;
        m_data = '0;
        m_strb = '0;
        m_resp = '0;
        t_acc = -1; t_aw = -1; t_w = -1; t_rs = -1; t_b = -1;
    endfunction

    always @(negedge aclk) begin
        bit e_aw, e_w, e_b, e_rv, e_to;
        e_aw = m_busy && (t_aw < 0);
        e_w  = m_busy && (t_w < 0) && (cyc >= t_acc + 1 + m_wd);
        e_b  = m_busy && (t_rs >= 0) && (t_b < 0) && (cyc >= t_rs + m_bd);
        e_rv = m_busy && (t_b >= 0) && (cyc == t_b + 1);
        e_to = m_busy && (t_b < 0) && (cyc == t_acc + TO);
        if (chk_en) begin
            ck1("req_ready", req_ready, !m_busy);
            ck1("awvalid", awvalid, e_aw);
            ck1("wvalid", wvalid, e_w);
            ck1("bready", bready, e_b);
            ck1("rsp_valid", rsp_valid, e_rv);
            ck1("rsp_timeout", rsp_timeout, e_to);
            chk("awaddr", 64'(awaddr), 64'(m_addr));
            chk("awprot", 64'(awprot), 64'(m_prot));
            chk("wdata", 64'(wdata), 64'(m_data));
            chk("wstrb", 64'(wstrb), 64'(m_strb));
            chk("rsp_resp", 64'(rsp_resp), 64'(m_resp));
        end
        if (!aresetn) begin
            model_reset();
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                t_acc = cyc; t_aw = -1; t_w = -1; t_rs = -1; t_b = -1;
                m_addr = req_addr;
                m_prot = req_prot;
                m_data = req_data;
                m_strb = req_strb;
                m_wd = int'(req_wvalid_delay);
                m_bd = int'(req_bready_delay);
            end
        end else begin
            if (e_aw && awready) t_aw = cyc;
            if (e_w && wready) t_w = cyc;
            if (t_aw >= 0 && t_w >= 0 && t_rs < 0) t_rs = cyc + 1;
            if (e_b && bvalid) begin
                t_b = cyc;
                m_resp = bresp;
            end
            if (e_rv) m_busy = 1'b0;
        end
        cyc++;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        req_valid = 1'b0;
        awready = 1'b1;
        wready = 1'b1;
        bvalid = 1'b1;
        bresp = 2'b00;
        for (int i = 0; i < 200 && !req_ready; i++) step();
        ck1("idle_reached", req_ready, 1'b1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int wd, input int bd);
        req_valid = 1'b1;
        req_addr = a;
        req_data = d;
        req_strb = s;
        req_prot = 3'd2;
        req_wvalid_delay = DLW'(wd);
        req_bready_delay = DLW'(bd);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int p_aw, p_w, p_b;
        repeat (3) step();
        chk_en = 1'b1;
        ck1("rst_req_ready", req_ready, 1'b1);
        ck1("rst_awvalid", awvalid, 1'b0);
        ck1("rst_bready", bready, 1'b0);
        chk("rst_awaddr", 64'(awaddr), 64'h0);
        aresetn = 1'b1;
        step();

        // back-to-back, zero delays, slave always ready
        wait_idle();
        send(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        ck1("t1_awvalid", awvalid, 1'b1);
        ck1("t1_wvalid", wvalid, 1'b1);
        ck1("t1_busy", req_ready, 1'b0);
        chk("t1_awaddr", 64'(awaddr), 64'h1000);
        chk("t1_wdata", 64'(wdata), 64'hDEAD_BEEF);
        req_valid = 1'b1;
        req_addr = 32'h0000_2000;
        req_data = 32'h0BAD_F00D;
        step();
        ck1("t1_bready", bready, 1'b1);
        step();
        ck1("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_resp", 64'(rsp_resp), 64'h0);
        step();
        ck1("t1_ready_again", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        ck1("t1_second_aw", awvalid, 1'b1);
        chk("t1_second_addr", 64'(awaddr), 64'h2000);

        // WVALID delay of 4
        wait_idle();
        send(32'h0000_3000, 32'h1234_5678, 4'h3, 4, 0);
        ck1("t2_aw_rise", awvalid, 1'b1);
        ck1("t2_w_low", wvalid, 1'b0);
        step();
        ck1("t2_aw_drop", awvalid, 1'b0);
        step();
        step();
        ck1("t2_w_still_low", wvalid, 1'b0);
        step();
        ck1("t2_w_rise", wvalid, 1'b1);
        chk("t2_wdata", 64'(wdata), 64'h1234_5678);

        // wready long before awready
        wait_idle();
        awready = 1'b0;
        send(32'h0000_4000, 32'hCAFE_0001, 4'hF, 0, 0);
        ck1("t3_aw", awvalid, 1'b1);
        step();
        ck1("t3_w_done", wvalid, 1'b0);
        step();
        step();
        ck1("t3_no_resp", bready, 1'b0);
        awready = 1'b1;
        step();
        ck1("t3_aw_drop", awvalid, 1'b0);
        ck1("t3_bready", bready, 1'b1);
        step();
        ck1("t3_rsp", rsp_valid, 1'b1);

        // BREADY delay 5, early bvalid with SLVERR
        wait_idle();
        bresp = 2'b10;
        send(32'h0000_5000, 32'h5555_AAAA, 4'hC, 0, 5);
        step();
        ck1("t4_b_low0", bready, 1'b0);
        repeat (4) step();
        ck1("t4_b_low4", bready, 1'b0);
        step();
        ck1("t4_b_rise", bready, 1'b1);
        step();
        ck1("t4_rsp", rsp_valid, 1'b1);
        chk("t4_slverr", 64'(rsp_resp), 64'h2);

        // timeout: awready withheld
        wait_idle();
        awready = 1'b0;
        send(32'h0000_6000, 32'h6666_6666, 4'hF, 0, 0);
        repeat (14) step();
        ck1("t5_to_before", rsp_timeout, 1'b0);
        step();
        ck1("t5_to_pulse", rsp_timeout, 1'b1);
        step();
        ck1("t5_to_once", rsp_timeout, 1'b0);
        ck1("t5_aw_held", awvalid, 1'b1);
        step();
        step();
        awready = 1'b1;
        step();
        ck1("t5_bready", bready, 1'b1);
        step();
        ck1("t5_rsp", rsp_valid, 1'b1);

        // reset during RESP
        wait_idle();
        bvalid = 1'b0;
        send(32'h0000_7000, 32'h7777_7777, 4'hF, 0, 10);
        step();
        ck1("t6_in_resp", bready, 1'b0);
        step();
        aresetn = 1'b0;
        step();
        ck1("t6_aw", awvalid, 1'b0);
        ck1("t6_w", wvalid, 1'b0);
        ck1("t6_b", bready, 1'b0);
        ck1("t6_ready", req_ready, 1'b1);
        chk("t6_addr", 64'(awaddr), 64'h0);
        aresetn = 1'b1;
        bvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            ck1("t6_no_rsp", rsp_valid, 1'b0);
        end

        // randomized traffic against the model
        p_aw = 50; p_w = 50; p_b = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                p_aw = $urandom_range(5, 100);
                p_w  = $urandom_range(5, 100);
                p_b  = $urandom_range(5, 100);
            end
            aresetn   = ($urandom_range(0, 299) != 0);
            awready   = ($urandom_range(0, 99) < p_aw);
            wready    = ($urandom_range(0, 99) < p_w);
            bvalid    = ($urandom_range(0, 99) < p_b);
            bresp     = 2'($urandom_range(0, 3));
            req_valid = ($urandom_range(0, 2) == 0);
            req_addr  = $urandom;
            req_data  = $urandom;
            req_strb  = SW'($urandom);
            req_prot  = 3'($urandom_range(0, 7));
            req_wvalid_delay = DLW'($urandom_range(0, 6));
            req_bready_delay = DLW'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) req_bready_delay = DLW'(20);
            step();
        end
        aresetn = 1'b1;
        wait_idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
